// File: rtl/hrm_dump_seq.sv
// Snapshot sequencer: freezes the HRM CPU, walks the dump mux and emits one
// framed byte stream (HEADER, PC, INSTR, REG, inbox, outbox, XOR checksum).
module hrm_dump_seq #(
    parameter int          FIFO_DEPTH  = 32,
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int          FREEZE_WAIT = 2
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_freeze,
    output logic [2:0] o_dmp_chip_select,
    output logic [4:0] o_dmp_fifo_pos,
    input  logic [7:0] i_dmp_data,
    input  logic       i_dmp_valid,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready
);

    localparam logic [2:0] CS_INBOX  = 3'd0;
    localparam logic [2:0] CS_OUTBOX = 3'd1;
    localparam logic [2:0] CS_PC     = 3'd2;
    localparam logic [2:0] CS_REG    = 3'd4;
    localparam logic [2:0] CS_INSTR  = 3'd5;
    localparam logic [5:0] DEPTH     = 6'(FIFO_DEPTH);
    localparam logic [4:0] LAST_POS  = 5'(FIFO_DEPTH - 1);
    localparam logic [7:0] WAIT_LEN  = 8'(FREEZE_WAIT);

    typedef enum logic [3:0] {
        S_IDLE, S_FREEZE, S_HDR, S_PC, S_INSTR, S_REG,
        S_SCAN_IN, S_CNT_IN, S_EMIT_IN,
        S_SCAN_OUT, S_CNT_OUT, S_EMIT_OUT,
        S_CKSUM, S_DONE
    } state_t;

    state_t     r_state, w_state_next;
    logic [7:0] r_wait, w_wait_next;
    logic       r_rd, w_rd_next;
    logic [2:0] r_sel, w_sel_next;
    logic [4:0] r_pos, w_pos_next;
    logic [5:0] r_cnt, w_cnt_next;
    logic [7:0] r_cksum, w_cksum_next;
    logic [7:0] r_tx_data, w_tx_data_next;
    logic       r_tx_valid, w_tx_valid_next;
    logic       r_busy, w_busy_next;
    logic       r_done, w_done_next;

    logic       w_hs;
    logic       w_is_read;
    logic       w_last_emit;
    logic [7:0] w_cksum_acc;
    logic [5:0] w_scan_cnt;

    assign w_hs        = r_tx_valid & i_tx_ready;
    assign w_cksum_acc = r_cksum ^ r_tx_data;
    assign w_last_emit = (({1'b0, r_pos} + 6'd1) == r_cnt);
    assign w_scan_cnt  = i_dmp_valid ? DEPTH : {1'b0, r_pos};
    assign w_is_read   = (r_state == S_PC) || (r_state == S_INSTR) || (r_state == S_REG) ||
                         (r_state == S_EMIT_IN) || (r_state == S_EMIT_OUT);

    always_comb begin
        w_state_next    = r_state;
        w_wait_next     = r_wait;
        w_rd_next       = r_rd;
        w_sel_next      = r_sel;
        w_pos_next      = r_pos;
        w_cnt_next      = r_cnt;
        w_cksum_next    = r_cksum;
        w_tx_data_next  = r_tx_data;
        w_tx_valid_next = r_tx_valid;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;

        // Two-cycle dump read: address held in the first cycle, data captured at the end of the second.
        if (w_is_read && !r_tx_valid) begin
            if (!r_rd) begin
                w_rd_next = 1'b1;
            end else begin
                w_rd_next       = 1'b0;
                w_tx_valid_next = 1'b1;
                w_tx_data_next  = i_dmp_data;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_FREEZE;
                    w_busy_next  = 1'b1;
                    w_wait_next  = 8'd0;
                    w_cksum_next = 8'd0;
                end
            end
            S_FREEZE: begin
                if (r_wait + 8'd1 >= WAIT_LEN) begin
                    w_state_next    = S_HDR;
                    w_tx_valid_next = 1'b1;
                    w_tx_data_next  = HEADER;
                end else begin
                    w_wait_next = r_wait + 8'd1;
                end
            end
            S_HDR: begin
                if (w_hs) begin
                    w_tx_valid_next = 1'b0;
                    w_sel_next      = CS_PC;
                    w_pos_next      = 5'd0;
                    w_rd_next       = 1'b0;
                    w_state_next    = S_PC;
                end
            end
            S_PC, S_INSTR, S_REG: begin
                if (w_hs) begin
                    w_tx_valid_next = 1'b0;
                    w_cksum_next    = w_cksum_acc;
                    if (r_state == S_PC) begin
                        w_sel_next   = CS_INSTR;
                        w_state_next = S_INSTR;
                    end else if (r_state == S_INSTR) begin
                        w_sel_next   = CS_REG;
                        w_state_next = S_REG;
                    end else begin
                        w_sel_next   = CS_INBOX;
                        w_pos_next   = 5'd0;
                        w_state_next = S_SCAN_IN;
                    end
                end
            end
            S_SCAN_IN, S_SCAN_OUT: begin
                if (!r_rd) begin
                    w_rd_next = 1'b1;
                end else begin
                    w_rd_next = 1'b0;
                    if (!i_dmp_valid || r_pos == LAST_POS) begin
                        w_cnt_next      = w_scan_cnt;
                        w_tx_valid_next = 1'b1;
                        w_tx_data_next  = {2'b00, w_scan_cnt};
                        w_pos_next      = 5'd0;
                        w_state_next    = (r_state == S_SCAN_IN) ? S_CNT_IN : S_CNT_OUT;
                    end else begin
                        w_pos_next = r_pos + 5'd1;
                    end
                end
            end
            S_CNT_IN, S_EMIT_IN: begin
                if (w_hs) begin
                    w_tx_valid_next = 1'b0;
                    w_cksum_next    = w_cksum_acc;
                    w_rd_next       = 1'b0;
                    if ((r_state == S_CNT_IN && r_cnt == 6'd0) ||
                        (r_state == S_EMIT_IN && w_last_emit)) begin
                        w_sel_next   = CS_OUTBOX;
                        w_pos_next   = 5'd0;
                        w_state_next = S_SCAN_OUT;
                    end else if (r_state == S_CNT_IN) begin
                        w_pos_next   = 5'd0;
                        w_state_next = S_EMIT_IN;
                    end else begin
                        w_pos_next = r_pos + 5'd1;
                    end
                end
            end
            S_CNT_OUT, S_EMIT_OUT: begin
                if (w_hs) begin
                    w_tx_valid_next = 1'b0;
                    w_cksum_next    = w_cksum_acc;
                    w_rd_next       = 1'b0;
                    if ((r_state == S_CNT_OUT && r_cnt == 6'd0) ||
                        (r_state == S_EMIT_OUT && w_last_emit)) begin
                        w_tx_valid_next = 1'b1;
                        w_tx_data_next  = w_cksum_acc;
                        w_state_next    = S_CKSUM;
                    end else if (r_state == S_CNT_OUT) begin
                        w_pos_next   = 5'd0;
                        w_state_next = S_EMIT_OUT;
                    end else begin
                        w_pos_next = r_pos + 5'd1;
                    end
                end
            end
            S_CKSUM: begin
                if (w_hs) begin
                    w_tx_valid_next = 1'b0;
                    w_busy_next     = 1'b0;
                    w_done_next     = 1'b1;
                    w_state_next    = S_DONE;
                end
            end
            S_DONE: begin
                w_sel_next   = CS_PC;
                w_pos_next   = 5'd0;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_wait     <= 8'd0;
            r_rd       <= 1'b0;
            r_sel      <= CS_PC;
            r_pos      <= 5'd0;
            r_cnt      <= 6'd0;
            r_cksum    <= 8'd0;
            r_tx_data  <= 8'd0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait     <= w_wait_next;
            r_rd       <= w_rd_next;
            r_sel      <= w_sel_next;
            r_pos      <= w_pos_next;
            r_cnt      <= w_cnt_next;
            r_cksum    <= w_cksum_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_valid <= w_tx_valid_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_freeze          = r_busy;
    assign o_dmp_chip_select = r_sel;
    assign o_dmp_fifo_pos    = r_pos;
    assign o_tx_data         = r_tx_data;
    assign o_tx_valid        = r_tx_valid;

endmodule

// File: tb/tb_hrm_dump_seq.sv
// Bench for hrm_dump_seq: a modelled CPU dump port, a frame model built from the
// FIFO contents, and a per-cycle monitor checking every accepted byte.
module tb_hrm_dump_seq;

    localparam int FW = 2;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic       o_busy, o_done, o_freeze;
    logic [2:0] o_dmp_chip_select;
    logic [4:0] o_dmp_fifo_pos;
    logic [7:0] i_dmp_data = 8'd0;
    logic       i_dmp_valid = 1'b0;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready = 1'b1;

    hrm_dump_seq #(.FIFO_DEPTH(32), .HEADER(8'hA5), .FREEZE_WAIT(FW)) dut (
        .clk(clk), .i_rst(i_rst), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_freeze(o_freeze),
        .o_dmp_chip_select(o_dmp_chip_select), .o_dmp_fifo_pos(o_dmp_fifo_pos),
        .i_dmp_data(i_dmp_data), .i_dmp_valid(i_dmp_valid),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready)
    );

    always #5 clk = ~clk;

    logic [7:0] m_inbox [32];
    logic [7:0] m_outbox[32];
    int         m_nin, m_nout;
    logic [7:0] m_pc, m_ir, m_r;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int  errors = 0;
    int  checks = 0;
    int  done_cnt = 0;
    int  hs_idx = 0;
    bit  mon_en = 1'b0;
    int  ready_mode = 0;
    int  stall_left = 0;
    int  stall_seen = 0;
    bit  prev_pending = 1'b0;
    logic [7:0] prev_data = 8'd0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // CPU dump port: registered lookup, so data for an address appears one cycle later.
    always @(posedge clk) begin
        case (o_dmp_chip_select)
            3'd2: begin i_dmp_data <= m_pc; i_dmp_valid <= 1'b1; end
            3'd5: begin i_dmp_data <= m_ir; i_dmp_valid <= 1'b1; end
            3'd4: begin i_dmp_data <= m_r;  i_dmp_valid <= 1'b1; end
            3'd0: begin
                i_dmp_valid <= (int'(o_dmp_fifo_pos) < m_nin);
                i_dmp_data  <= (int'(o_dmp_fifo_pos) < m_nin) ? m_inbox[o_dmp_fifo_pos] : 8'($urandom);
            end
            3'd1: begin
                i_dmp_valid <= (int'(o_dmp_fifo_pos) < m_nout);
                i_dmp_data  <= (int'(o_dmp_fifo_pos) < m_nout) ? m_outbox[o_dmp_fifo_pos] : 8'($urandom);
            end
            default: begin i_dmp_data <= 8'($urandom); i_dmp_valid <= 1'b0; end
        endcase
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: i_tx_ready = 1'b1;
                1: i_tx_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (hs_idx == 6 && o_tx_valid && stall_left > 0) begin
                        i_tx_ready = 1'b0;
                        stall_left--;
                    end else begin
                        i_tx_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("freeze_eq_busy", int'(o_freeze), int'(o_busy));
            chk("pos_in_range", int'(o_dmp_fifo_pos <= 5'd31), 1);
            if (prev_pending) begin
                chk("valid_held", int'(o_tx_valid), 1);
                chk("data_held", int'(o_tx_data), int'(prev_data));
            end
            if (o_done) done_cnt++;
            if (o_tx_valid && !i_tx_ready && hs_idx == 6 && ready_mode == 2) stall_seen++;
            if (o_tx_valid && i_tx_ready) begin
                chk("freeze_in_frame", int'(o_freeze), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", exp_q.size(), 1);
                end else begin
                    chk($sformatf("byte%0d", hs_idx), int'(o_tx_data), int'(exp_q.pop_front()));
                end
                rx_q.push_back(o_tx_data);
                hs_idx++;
            end
            prev_pending = o_tx_valid && !i_tx_ready;
            prev_data    = o_tx_data;
        end else begin
            prev_pending = 1'b0;
        end
    end

    // Frame model: straight from the frame layout and XOR-of-everything-after-header rule.
    task automatic build_expected();
        logic [7:0] ck;
        exp_q.delete();
        rx_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(m_pc);
        exp_q.push_back(m_ir);
        exp_q.push_back(m_r);
        exp_q.push_back(8'(m_nin));
        for (int i = 0; i < m_nin; i++) exp_q.push_back(m_inbox[i]);
        exp_q.push_back(8'(m_nout));
        for (int i = 0; i < m_nout; i++) exp_q.push_back(m_outbox[i]);
        ck = 8'd0;
        for (int i = 1; i < exp_q.size(); i++) ck ^= exp_q[i];
        exp_q.push_back(ck);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int mode, input bit spam);
        int t;
        int cyc;
        build_expected();
        done_cnt   = 0;
        hs_idx     = 0;
        ready_mode = mode;
        stall_left = 10;
        stall_seen = 0;
        pulse_start();
        chk("freeze_after_start", int'(o_freeze), 1);
        chk("busy_after_start", int'(o_busy), 1);
        t = 0;
        while (!o_tx_valid && t < 20) begin
            @(posedge clk);
            #1 t++;
        end
        chk("hdr_latency", int'(t <= FW + 2), 1);
        cyc = 0;
        while (done_cnt == 0 && cyc < 4000) begin
            @(posedge clk);
            #1 i_start = spam && o_busy && ($urandom_range(0, 1) == 1);
            cyc++;
        end
        i_start = 1'b0;
        chk("done_seen", int'(done_cnt > 0), 1);
        repeat (6) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt, 1);
        chk("bytes_missing", exp_q.size(), 0);
        chk("frame_len", rx_q.size(), 7 + m_nin + m_nout);
        chk("idle_after", int'(o_busy), 0);
        $display("frame %s: nin=%0d nout=%0d bytes=%0d cksum=0x%02h", tag, m_nin, m_nout,
                 rx_q.size(), (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : 8'h00);
    endtask

    task automatic set_base();
        m_pc = 8'h05; m_ir = 8'h20; m_r = 8'h07;
        m_nin = 3; m_nout = 1;
        m_inbox[0] = 8'h03; m_inbox[1] = 8'h01; m_inbox[2] = 8'h04;
        m_outbox[0] = 8'h09;
    endtask

    initial begin
        logic [7:0] lit1 [7];
        logic [7:0] lit2 [11];
        int c;
        lit1 = '{8'hA5, 8'h05, 8'h20, 8'h07, 8'h00, 8'h00, 8'h22};
        lit2 = '{8'hA5, 8'h05, 8'h20, 8'h07, 8'h03, 8'h03, 8'h01, 8'h04, 8'h01, 8'h09, 8'h2F};
        m_pc = 8'h05; m_ir = 8'h20; m_r = 8'h07; m_nin = 0; m_nout = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_freeze", int'(o_freeze), 0);
        chk("rst_sel", int'(o_dmp_chip_select), 2);
        chk("rst_pos", int'(o_dmp_fifo_pos), 0);
        chk("rst_valid", int'(o_tx_valid), 0);
        chk("rst_data", int'(o_tx_data), 0);
        i_rst = 1'b0;
        mon_en = 1'b1;

        run_frame("empty", 0, 1'b0);
        for (int i = 0; i < 7; i++) chk($sformatf("lit_empty%0d", i), int'(rx_q[i]), int'(lit1[i]));

        set_base();
        run_frame("base", 0, 1'b0);
        for (int i = 0; i < 11; i++) chk($sformatf("lit_base%0d", i), int'(rx_q[i]), int'(lit2[i]));

        set_base();
        run_frame("stall", 2, 1'b0);
        chk("stall_cycles", stall_seen, 10);
        chk("stall_byte", int'(rx_q[6]), 8'h01);

        m_nin = 32; m_nout = 0;
        for (int i = 0; i < 32; i++) m_inbox[i] = 8'(i);
        run_frame("full_in", 1, 1'b0);
        chk("full_len", rx_q.size(), 39);
        chk("full_cnt", int'(rx_q[4]), 8'h20);
        chk("full_last", int'(rx_q[36]), 8'h1F);

        set_base();
        build_expected();
        hs_idx = 0;
        ready_mode = 0;
        pulse_start();
        c = 0;
        while (hs_idx < 5 && c < 200) begin
            @(posedge clk);
            #1 c++;
        end
        chk("reach_emit_in", int'(hs_idx >= 5), 1);
        mon_en = 1'b0;
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", int'(o_tx_valid), 0);
        chk("midrst_freeze", int'(o_freeze), 0);
        chk("midrst_busy", int'(o_busy), 0);
        chk("midrst_pos", int'(o_dmp_fifo_pos), 0);
        i_rst = 1'b0;
        mon_en = 1'b1;
        run_frame("after_rst", 0, 1'b0);
        chk("after_rst_hdr", int'(rx_q[0]), 8'hA5);

        set_base();
        run_frame("spam", 1, 1'b1);

        for (int k = 0; k < 8; k++) begin
            m_pc = 8'($urandom); m_ir = 8'($urandom); m_r = 8'($urandom);
            m_nin  = (k == 3) ? 32 : int'($urandom_range(0, 32));
            m_nout = (k == 5) ? 32 : int'($urandom_range(0, 32));
            for (int i = 0; i < 32; i++) begin
                m_inbox[i]  = 8'($urandom);
                m_outbox[i] = 8'($urandom);
            end
            run_frame($sformatf("rand%0d", k), 1, (k % 2) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
